onehot_decoder: RTL and testbench
=================================

ONEHOT_DECODER -- requirements
Module: onehot_decoder

Interface
REQ-001 SHALL have parameter IN_W, default 8: width of one-hot input; power of two, >= 2.
REQ-002 SHALL have parameter OUT_W, default $clog2(IN_W): width of decoded index.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream word present.
REQ-006 SHALL have port in_ready  output  1  block accepts word this cycle.
REQ-007 SHALL have port in  input  IN_W  one-hot code; bit i set encodes index i.
REQ-008 SHALL have port out_valid  output  1  decoded word present.
REQ-009 SHALL have port out_ready  input  1  downstream accepts word this cycle.
REQ-010 SHALL have port out  output  OUT_W  decoded index.
REQ-011 SHALL have port out_err  output  1  accompanying input was not exactly one-hot.
REQ-012 SHALL have port err_cnt  output  8  saturating count of accepted malformed words.

Function
REQ-013 SHALL transfer on input when in_valid && in_ready, and on output when out_valid && out_ready.
REQ-014 SHALL decode a well-formed input with exactly bit i set to out = i, out_err = 0; exact inverse of the unsigned-to-one-hot encoder (index 0 <-> 0..01).
REQ-015 SHALL decode an all-zero input to out = 0, out_err = 1.
REQ-016 SHALL decode an input with two or more bits set to out = lowest set bit index, out_err = 1.
REQ-017 SHALL present an accepted word on out/out_err/out_valid exactly one cycle after acceptance (registered output, latency 1).
REQ-018 SHALL implement a two-entry skid buffer with states EMPTY, ONE (output reg full), TWO (output and skid regs full).
REQ-019 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in TWO; in_ready SHALL come from a register, not combinationally from out_ready.
REQ-020 SHALL transition EMPTY->ONE on input transfer; ONE->EMPTY on output transfer without input transfer; ONE->ONE on simultaneous input and output transfer (new word loaded to output reg); ONE->TWO on input transfer without output transfer (word loaded to skid reg).
REQ-021 SHALL transition TWO->ONE on output transfer, moving skid contents to output reg; TWO holds otherwise.
REQ-022 SHALL hold out, out_err stable while out_valid && !out_ready.
REQ-023 SHALL preserve word order; no word dropped or duplicated; sustained throughput one word per cycle while out_ready = 1.
REQ-024 SHALL ignore in (no decode side effects, no count) when no input transfer occurs.

Reset
REQ-025 SHALL, on reset_n low, immediately enter EMPTY and drive out_valid = 0, in_ready = 0, out = 0, out_err = 0, err_cnt = 0.
REQ-026 SHALL drive in_ready = 1 on the first rising edge after reset_n deasserts.
REQ-027 SHALL discard all buffered words when reset asserts mid-operation, including in state TWO.

Configuration
REQ-028 SHALL compile the error counter only when macro ONEHOT_DECODER_ERRCNT_EN is defined.
REQ-029 SHALL, with ONEHOT_DECODER_ERRCNT_EN defined, increment err_cnt by 1 on each input transfer whose word is malformed, saturating at 255.
REQ-030 SHALL, without ONEHOT_DECODER_ERRCNT_EN, tie err_cnt to 0 and instantiate no counter flops; all other behaviour identical.

Verification
REQ-031 SHALL sweep i = 0..7 with in = 1<<i, out_ready = 1 -> out = i, out_err = 0, one cycle after each acceptance, back-to-back.
REQ-032 SHALL apply in = 8'h00 then 8'b0001_0100 -> out = 0, out_err = 1 then out = 2, out_err = 1; err_cnt = 2 (macro defined) or 0 (undefined).
REQ-033 SHALL hold out_ready = 0 and offer 3 words (1<<3, 1<<5, 1<<6) -> two accepted, in_ready = 0 in TWO, out = 3 held stable; release out_ready -> out 3, 5, 6 in order, none lost.
REQ-034 SHALL toggle out_ready randomly for 1000 words of random valid one-hot input -> output sequence equals input indices in order, no out_err.
REQ-035 SHALL assert reset_n low while in TWO -> out_valid = 0, err_cnt = 0 immediately, without clock; first word after release decodes correctly.
REQ-036 SHALL feed 300 malformed words with macro defined -> err_cnt reaches 255 and stays 255.

Source files
------------

// File: rtl/onehot_decoder.sv
// One-hot to index decoder behind a two-entry registered skid buffer.
// Define ONEHOT_DECODER_ERRCNT_EN to build the malformed-word counter.
module onehot_decoder #(
  parameter int IN_W  = 8,
  parameter int OUT_W = $clog2(IN_W)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out,
  output logic             out_err,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t state, state_n;

  logic             rdy_q;
  logic [OUT_W-1:0] out_q;
  logic             err_q;
  logic [OUT_W-1:0] skid_q;
  logic             skid_err_q;

  logic             in_xfer;
  logic             out_xfer;
  logic             load_out;
  logic             load_skid;
  logic             move_skid;
  logic [OUT_W-1:0] dec_idx;
  logic             dec_err;

  // lowest set bit wins when the word is malformed
  always_comb begin
    dec_idx = '0;
    for (int i = IN_W - 1; i >= 0; i--) begin
      if (in[i]) dec_idx = OUT_W'(i);
    end
  end

  assign dec_err = (in == '0) ||
                   ((in & (in - IN_W'(1))) != '0);

  assign in_ready  = rdy_q;
  assign out_valid = (state != EMPTY);
  assign out       = out_q;
  assign out_err   = err_q;
  assign in_xfer   = in_valid && rdy_q;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    state_n   = state;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_n  = ONE;
          load_out = 1'b1;
        end
      end
      ONE: begin
        unique case (1'b1)
          (in_xfer && out_xfer): begin
            load_out = 1'b1;
          end
          (in_xfer && !out_xfer): begin
            state_n   = TWO;
            load_skid = 1'b1;
          end
          (!in_xfer && out_xfer): begin
            state_n = EMPTY;
          end
          default: ;
        endcase
      end
      TWO: begin
        if (out_xfer) begin
          state_n   = ONE;
          move_skid = 1'b1;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  // ready is registered so it never depends on out_ready combinationally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
      rdy_q <= 1'b0;
    end else begin
      state <= state_n;
      rdy_q <= (state_n != TWO);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q      <= '0;
      err_q      <= 1'b0;
      skid_q     <= '0;
      skid_err_q <= 1'b0;
    end else begin
      if (load_out) begin
        out_q <= dec_idx;
        err_q <= dec_err;
      end else if (move_skid) begin
        out_q <= skid_q;
        err_q <= skid_err_q;
      end
      if (load_skid) begin
        skid_q     <= dec_idx;
        skid_err_q <= dec_err;
      end
    end
  end

`ifdef ONEHOT_DECODER_ERRCNT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 8'd0;
    end else if (in_xfer && dec_err && cnt_q != 8'hFF) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign err_cnt = cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_onehot_decoder.sv
// Scoreboard bench for onehot_decoder: expected words queued on
// acceptance, compared at the output; occupancy model checks handshakes.
module tb_onehot_decoder;

`ifdef ONEHOT_DECODER_ERRCNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] dout;
  logic       out_err;
  logic [7:0] err_cnt;

  onehot_decoder #(
    .IN_W (8),
    .OUT_W(3)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in       (din),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (dout),
    .out_err  (out_err),
    .err_cnt  (err_cnt)
  );

  typedef struct packed {
    logic       err;
    logic [2:0] idx;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_cnt  = 0;
  bit   armed    = 0;
  bit   rnd_on   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [7:0] w);
    exp_t r;
    r.idx = 3'd0;
    r.err = ($countones(w) != 1);
    for (int i = 0; i < 8; i++) begin
      if (w[i]) begin
        r.idx = 3'(i);
        break;
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) armed = 0;
    else armed = 1;
  end

  // Monitor: occupancy model, front-of-queue, counter.
  always @(negedge clk) begin
    if (reset_n) begin
      exp_t e;
      check("in_ready", in_ready,
            32'(armed && q.size() < 2));
      check("out_valid", out_valid,
            32'(q.size() != 0));
      if (out_valid && q.size() != 0) begin
        check("out", dout, q[0].idx);
        check("out_err", out_err, q[0].err);
      end
      check("err_cnt", err_cnt, exp_cnt);
      if (out_valid && out_ready && q.size() != 0)
        void'(q.pop_front());
      if (in_valid && in_ready) begin
        e = model(din);
        q.push_back(e);
        if (CNT_EN == 1 && e.err && exp_cnt < 255)
          exp_cnt++;
      end
    end
  end

  task automatic send(input logic [7:0] w);
    bit ok;
    ok = 0;
    din = w;
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b1;
    in_valid  = 1'b0;
    din       = 8'h00;
    out_ready = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out", dout, 0);
    check("rst_out_err", out_err, 0);
    check("rst_err_cnt", err_cnt, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    check("ready_pre_edge", in_ready, 0);
    @(posedge clk);
    #1;
    check("ready_post_edge", in_ready, 1);

    // back-to-back sweep of every index
    for (int i = 0; i < 8; i++) begin
      logic [7:0] w;
      w = 8'd1 << i;
      send(w);
    end
    drain();

    // malformed: all-zero and two bits set
    send(8'h00);
    send(8'b0001_0100);
    drain();
    check("errcnt_two", err_cnt, CNT_EN ? 2 : 0);

    // stall: two accepted, third waits
    out_ready = 1'b0;
    send(8'd1 << 3);
    send(8'd1 << 5);
    fork
      send(8'd1 << 6);
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_ready", in_ready, 0);
          check("stall_out", dout, 3);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // random one-hot stream with random backpressure
    rnd_on = 1;
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          logic [7:0] w;
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          w = 8'd1 << $urandom_range(0, 7);
          send(w);
        end
        rnd_on = 0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // reset while both entries are full
    out_ready = 1'b0;
    send(8'd1 << 1);
    send(8'd1 << 2);
    @(negedge clk);
    check("two_ready", in_ready, 0);
    #2 reset_n = 1'b0;
    #1;
    check("rst2_out_valid", out_valid, 0);
    check("rst2_in_ready", in_ready, 0);
    check("rst2_err_cnt", err_cnt, 0);
    check("rst2_out", dout, 0);
    q.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    send(8'd1 << 4);
    drain();

    // counter saturation
    for (int n = 0; n < 300; n++) begin
      logic [7:0] w;
      w = (n % 3 == 0) ? 8'h00
          : (8'h03 << $urandom_range(0, 6));
      send(w);
    end
    drain();
    check("errcnt_sat", err_cnt, CNT_EN ? 255 : 0);
    repeat (3) @(posedge clk);
    #1;
    check("errcnt_hold", err_cnt, CNT_EN ? 255 : 0);
    check("sb_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
